hash_arb: RTL



---
 rtl/hash_pkg.sv | 20 ++
 rtl/hash_arb_rr_pick.sv | 30 +++
 rtl/hash_arb.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/hash_pkg.sv
// Shared definitions for the hash table front end: op bit layout, op legality
// and the arbiter state encoding.
package hash_pkg;

  localparam int OP_ADD    = 0;
  localparam int OP_UPDATE = 1;
  localparam int OP_DEL    = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  // Delete combined with add or update has no meaning to the table.
  function automatic logic op_legal(input logic [2:0] op);
    return !(op[OP_DEL] && (op[OP_ADD] || op[OP_UPDATE]));
  endfunction

endpackage

// File: rtl/hash_arb_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo N.
module rr_pick #(
  parameter int  N  = 3,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);

  logic [IW:0] w_sum;

  // NOTE: every output of this block gets a default before the loop, so no latch is inferred.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    w_sum = '0;
    for (int i = 0; i < N; i++) begin
      w_sum = {1'b0, ptr} + (IW+1)'(i);
      if (w_sum >= (IW+1)'(N)) w_sum = w_sum - (IW+1)'(N);
      if (!valid && req[w_sum[IW-1:0]]) begin
        valid = 1'b1;
        idx   = w_sum[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/hash_arb.sv
// Round-robin arbiter that serialises client requests onto the single command
// port of one hash table and routes each response back to its requester.
module hash_arb
  import hash_pkg::*;
#(
  parameter int NREQ       = 3,
  parameter int KEYWIDTH   = 20,
  parameter int HTWIDTH    = 10,
  parameter int VALUEWIDTH = 2
) (
  input  logic                       clk,
  input  logic                       reset_l,
  input  logic [NREQ-1:0]            cl_req,
  input  logic [3*NREQ-1:0]          cl_op,
  input  logic [KEYWIDTH*NREQ-1:0]   cl_key,
  input  logic [VALUEWIDTH*NREQ-1:0] cl_value,
  output logic [NREQ-1:0]            cl_ack,
  output logic                       rsp_found,
  output logic [VALUEWIDTH-1:0]      rsp_value,
  output logic                       rsp_ovf,
  output logic                       rsp_err,
  output logic                       h_req,
  output logic                       h_add,
  output logic                       h_update,
  output logic                       h_del,
  output logic [KEYWIDTH-1:0]        h_key,
  output logic [VALUEWIDTH-1:0]      h_value,
  input  logic                       h_ack,
  input  logic                       h_found,
  input  logic [VALUEWIDTH-1:0]      h_found_value,
  input  logic [HTWIDTH:0]           h_count,
  output logic                       busy,
  output logic [2:0]                 grant_id
);

  localparam int                IW     = $clog2(NREQ);
  localparam logic [HTWIDTH:0]  FULL   = {1'b1, {HTWIDTH{1'b0}}};
  localparam logic [NREQ-1:0]   ONEHOT = NREQ'(1);

  state_t                  r_state;
  logic [IW-1:0]           r_rr_ptr;
  logic [IW-1:0]           r_grant;
  logic [NREQ-1:0]         r_cl_ack;
  logic                    r_h_req;
  logic                    r_h_add;
  logic                    r_h_update;
  logic                    r_h_del;
  logic [KEYWIDTH-1:0]     r_h_key;
  logic [VALUEWIDTH-1:0]   r_h_value;
  logic                    r_rsp_found;
  logic [VALUEWIDTH-1:0]   r_rsp_value;
  logic                    r_rsp_ovf;
  logic                    r_rsp_err;

  logic [NREQ-1:0]         w_req_masked;
  logic                    w_pick_valid;
  logic [IW-1:0]           w_pick_idx;
  logic [2:0]              w_op;
  logic [KEYWIDTH-1:0]     w_key;
  logic [VALUEWIDTH-1:0]   w_value;
  logic [IW-1:0]           w_next_ptr;

  // A client still sees its own ack this cycle, so its level is not a new request yet.
  assign w_req_masked = cl_req & ~r_cl_ack;

  rr_pick #(.N(NREQ)) u_pick (
    .req   (w_req_masked),
    .ptr   (r_rr_ptr),
    .valid (w_pick_valid),
    .idx   (w_pick_idx)
  );

  assign w_op       = cl_op[3*w_pick_idx +: 3];
  assign w_key      = cl_key[KEYWIDTH*w_pick_idx +: KEYWIDTH];
  assign w_value    = cl_value[VALUEWIDTH*w_pick_idx +: VALUEWIDTH];
  assign w_next_ptr = (w_pick_idx == IW'(NREQ-1)) ? '0 : w_pick_idx + 1'b1;

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= '0;
      r_grant     <= '0;
      r_cl_ack    <= '0;
      r_h_req     <= 1'b0;
      r_h_add     <= 1'b0;
      r_h_update  <= 1'b0;
      r_h_del     <= 1'b0;
      r_h_key     <= '0;
      r_h_value   <= '0;
      r_rsp_found <= 1'b0;
      r_rsp_value <= '0;
      r_rsp_ovf   <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pick_valid) begin
            r_grant    <= w_pick_idx;
            r_rr_ptr   <= w_next_ptr;
            r_h_add    <= w_op[OP_ADD];
            r_h_update <= w_op[OP_UPDATE];
            r_h_del    <= w_op[OP_DEL];
            r_h_key    <= w_key;
            r_h_value  <= w_value;
            if (op_legal(w_op)) begin
              r_h_req <= 1'b1;
              r_state <= ST_ISSUE;
            end else begin
              // Rejected without touching the table; answer straight away.
              r_rsp_err   <= 1'b1;
              r_rsp_found <= 1'b0;
              r_rsp_value <= '0;
              r_rsp_ovf   <= 1'b0;
              r_cl_ack    <= ONEHOT << w_pick_idx;
              r_state     <= ST_RESP;
            end
          end
        end
        ST_ISSUE: begin
          if (h_ack) begin
            r_h_req     <= 1'b0;
            r_rsp_found <= h_found;
            r_rsp_value <= h_found_value;
            r_rsp_ovf   <= r_h_add & ~r_h_update & ~h_found & (h_count == FULL);
            r_rsp_err   <= 1'b0;
            r_cl_ack    <= ONEHOT << r_grant;
            r_state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          r_cl_ack <= '0;
          r_state  <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cl_ack    = r_cl_ack;
  assign rsp_found = r_rsp_found;
  assign rsp_value = r_rsp_value;
  assign rsp_ovf   = r_rsp_ovf;
  assign rsp_err   = r_rsp_err;
  assign h_req     = r_h_req;
  assign h_add     = r_h_add;
  assign h_update  = r_h_update;
  assign h_del     = r_h_del;
  assign h_key     = r_h_key;
  assign h_value   = r_h_value;
  assign busy      = (r_state != ST_IDLE);
  assign grant_id  = 3'(r_grant);

endmodule
